uart_rx_engine: RTL and testbench
=================================

// Module: uart_rx_engine
// PURPOSE
//  Parametrised UART receive engine: oversampled start-bit qualification, LSB-first data capture,
//  optional even/odd parity, 1 or 2 stop bits. Sits between the serial RX pin and the
//  host-side buffer. Delivers each word over a valid/ready handshake, with per-word
//  parity, framing and overrun status.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, legal 5..9
//  PARITY_MODE 0   0 = none, 1 = even, 2 = odd
//  STOP_BITS   1   stop bits checked, legal 1 or 2
//  OVERSAMPLE  16  i_sample_tick pulses per bit period, even, >= 4
// PORTS
//  i_clk          in   1          system clock, rising edge
//  i_reset        in   1          asynchronous, active-high reset
//  i_sample_tick  in   1          one-cycle enable at OVERSAMPLE x baud rate
//  i_rx           in   1          serial line, idle high; asynchronous to i_clk
//  o_data         out  DATA_BITS  received word, LSB = first bit on the line
//  o_valid        out  1          o_data and status are valid
//  i_ready        in   1          consumer accepts the word while o_valid = 1
//  o_parity_err   out  1          parity mismatch for the word in o_data
//  o_frame_err    out  1          any stop bit sampled 0 for the word in o_data
//  o_overrun      out  1          sticky: a frame completed while o_valid was held
//  o_busy         out  1          FSM not in IDLE
// BEHAVIOUR
//  Clock, reset and input sync
//  - One clock, i_clk. i_reset is asynchronous and active-high.
//  - i_rx passes through a 2-flop synchroniser (reset value 1); all logic uses the synced value.
//  - Reset: FSM = IDLE, all counters = 0, o_data = 0. o_valid, o_parity_err, o_frame_err,
//    o_overrun and o_busy are all 0.
//  - Reset mid-frame aborts the frame with no output. After release, a new start is detected
//    only on a fresh 1->0 edge.
//  Tick and bit counting
//  - Tick counter width $clog2(OVERSAMPLE). It advances only on i_sample_tick.
//  - Bit counter width $clog2(DATA_BITS+1).
//  State machine
//  - IDLE: on synced 1->0 edge -> START and clear the tick counter.
//  - START: after OVERSAMPLE/2 ticks (mid-bit), sample the line.
//    If 0 -> DATA. If 1 -> false start, back to IDLE, no output.
//  - DATA: every OVERSAMPLE ticks, sample one bit into a shift register, LSB first.
//    After DATA_BITS samples -> PARITY if PARITY_MODE != 0, else -> STOP.
//  - PARITY: one OVERSAMPLE-tick sample.
//    Even parity: XOR of data bits and parity bit must be 0. Odd parity: it must be 1.
//  - STOP: STOP_BITS samples, each OVERSAMPLE ticks apart. A 0 in any of them sets the
//    frame error. After the last sample -> IDLE in the same cycle and complete the frame.
//  - A frame error does not stall the FSM. A held-low line (break) yields a frame error,
//    then waits in IDLE until a new falling edge.
//  Frame completion (the i_clk cycle after the final stop-bit sample)
//  - If o_valid = 0: load o_data, o_parity_err and o_frame_err; set o_valid = 1.
//  - If o_valid = 1 and i_ready = 0: drop the new word, keep the held word, set o_overrun.
//  - If o_valid = 1 and i_ready = 1 in that same cycle: load the new word, keep o_valid = 1,
//    no overrun.
//  Handshake
//  - o_valid stays high until a cycle with i_ready = 1; it drops the next cycle.
//  - o_data and both error flags are stable while o_valid = 1.
//  - o_overrun clears only on a cycle with o_valid & i_ready, or on reset.
//  - i_ready while o_valid = 0 has no effect.
//  Throughput
//  - Back-to-back frames are supported: IDLE can detect the next start edge one cycle after
//    the stop bit completes.
// TESTING
//  1. 8N1 defaults, send 0xA5, i_ready = 1 -> one-cycle o_valid, o_data = 0xA5, no error flags.
//  2. DATA_BITS = 7, PARITY_MODE = 1, send 0x41 with parity bit 1 -> o_data = 0x41, o_parity_err = 1.
//     Same word with parity bit 0 -> o_parity_err = 0.
//  3. Low glitch of OVERSAMPLE/4 ticks on an idle line -> o_busy returns to 0, o_valid never asserts.
//  4. STOP_BITS = 2, send 0x3C with second stop bit = 0 -> o_data = 0x3C, o_frame_err = 1,
//     next frame 0x5A received cleanly.
//  5. i_ready = 0, send 0x11 then 0x22 -> o_data stays 0x11, o_overrun = 1.
//     Raise i_ready -> o_valid and o_overrun both clear.
//  6. Assert i_reset during DATA bit 3 of 0xFF -> all outputs 0.
//     After release, a following 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_engine.sv
// uart_rx_engine
//   Oversampled UART receiver. Qualifies the start bit at mid-bit, shifts data in
//   LSB first, optionally checks even/odd parity, checks 1 or 2 stop bits, and
//   hands each word to the host over a valid/ready handshake with status flags.
// Ports
//   i_clk, i_reset      clock (rising edge), async active-high reset
//   i_sample_tick       one-cycle enable at OVERSAMPLE x baud
//   i_rx                serial line, idle high, asynchronous to i_clk
//   o_data, o_valid     received word and its valid flag
//   i_ready             consumer accepts the word while o_valid = 1
//   o_parity_err        parity mismatch for the word in o_data
//   o_frame_err         a stop bit sampled 0 for the word in o_data
//   o_overrun           sticky: a frame completed while the previous word was held
//   o_busy              receiver is inside a frame
module uart_rx_engine #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_sample_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] MID       = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL      = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY_MODE == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic                 rx_meta, rx_s, rx_prev;
  logic                 fall, sample, frame_done;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err_q, frm_err_q;

  // Synchroniser resets to idle-high so the line looks quiet coming out of reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall   = rx_prev & ~rx_s;
  assign o_busy = (state_q != IDLE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    sample     = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE:   if (fall) state_d = START;
      START:  if (i_sample_tick && tick_cnt == MID) state_d = rx_s ? IDLE : DATA;
      DATA:   if (i_sample_tick && tick_cnt == FULL) begin
        sample = 1'b1;
        if (bit_cnt == LAST_DATA) state_d = (PARITY_MODE != 0) ? PARITY : STOP;
      end
      PARITY: if (i_sample_tick && tick_cnt == FULL) begin
        sample  = 1'b1;
        state_d = STOP;
      end
      STOP:   if (i_sample_tick && tick_cnt == FULL) begin
        sample = 1'b1;
        if (bit_cnt == LAST_STOP) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tick counter restarts on every sample point and on the start->data
  // transition, so each later sample lands one full bit after the previous.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      if (state_q == IDLE)
        tick_cnt <= '0;
      else if (i_sample_tick)
        tick_cnt <= (sample || state_d != state_q) ? '0 : tick_cnt + 1'b1;

      if (state_d != state_q) bit_cnt <= '0;
      else if (sample)        bit_cnt <= bit_cnt + 1'b1;

      if (state_q == START) begin
        par_err_q <= 1'b0;
        frm_err_q <= 1'b0;
      end
      if (sample && state_q == DATA)   shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      if (sample && state_q == PARITY) par_err_q <= (^shreg) ^ rx_s ^ ODD;
      if (sample && state_q == STOP && !rx_s) frm_err_q <= 1'b1;
    end
  end

  // Output holding register. The final stop sample is folded in directly so
  // the word is offered the cycle after that sample.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      if (o_valid && i_ready) begin
        o_valid   <= 1'b0;
        o_overrun <= 1'b0;
      end
      if (frame_done) begin
        if (!o_valid || i_ready) begin
          o_data       <= shreg;
          o_parity_err <= par_err_q;
          o_frame_err  <= frm_err_q | ~rx_s;
          o_valid      <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine. Three instances share clock, reset, tick
// and ready: 8N1 (a), 7E1 (b) and 8N2 (c). One bit period = 16 ticks = 32 clocks.
module tb_uart_rx_engine;

  logic clk = 1'b0;
  logic rst, tick, ready;
  logic rx_a, rx_b, rx_c;

  logic [7:0] da; logic va, pea, fea, ova, ba;
  logic [6:0] db; logic vb, peb, feb, ovb, bb;
  logic [7:0] dc; logic vc, pec, fec, ovc, bc;

  int errs = 0, checks = 0;
  int cnt_a = 0, cnt_b = 0, cnt_c = 0;
  logic [7:0] cap_da = '0, cap_dc = '0;
  logic [6:0] cap_db = '0;
  logic cap_pea = 0, cap_fea = 0, cap_peb = 0, cap_fec = 0, cap_pec = 0;

  always #5 clk = ~clk;

  uart_rx_engine u_a (
    .i_clk(clk), .i_reset(rst), .i_sample_tick(tick), .i_rx(rx_a),
    .o_data(da), .o_valid(va), .i_ready(ready), .o_parity_err(pea),
    .o_frame_err(fea), .o_overrun(ova), .o_busy(ba));

  uart_rx_engine #(.DATA_BITS(7), .PARITY_MODE(1)) u_b (
    .i_clk(clk), .i_reset(rst), .i_sample_tick(tick), .i_rx(rx_b),
    .o_data(db), .o_valid(vb), .i_ready(ready), .o_parity_err(peb),
    .o_frame_err(feb), .o_overrun(ovb), .o_busy(bb));

  uart_rx_engine #(.STOP_BITS(2)) u_c (
    .i_clk(clk), .i_reset(rst), .i_sample_tick(tick), .i_rx(rx_c),
    .o_data(dc), .o_valid(vc), .i_ready(ready), .o_parity_err(pec),
    .o_frame_err(fec), .o_overrun(ovc), .o_busy(bc));

  // Capture every word presented, counting valid-high cycles.
  always @(negedge clk) begin
    if (va) begin cnt_a++; cap_da = da; cap_pea = pea; cap_fea = fea; end
    if (vb) begin cnt_b++; cap_db = db; cap_peb = peb; end
    if (vc) begin cnt_c++; cap_dc = dc; cap_fec = fec; cap_pec = pec; end
  end

  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk); #1 tick = ~tick;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int w, input logic v);
    case (w)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic send_frame(input int w, input logic [8:0] d, input int nb,
                            input int pen, input logic pb,
                            input logic s0, input logic s1, input int nstop);
    set_rx(w, 1'b0); clks(32);
    for (int i = 0; i < nb; i++) begin set_rx(w, d[i]); clks(32); end
    if (pen != 0) begin set_rx(w, pb); clks(32); end
    set_rx(w, s0); clks(32);
    if (nstop == 2) begin set_rx(w, s1); clks(32); end
    set_rx(w, 1'b1); clks(64);
  endtask

  int n;

  initial begin
    rst = 1'b1; ready = 1'b1; rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    clks(3);
    chk("reset_valid",   32'(va), 0);
    chk("reset_data",    32'(da), 0);
    chk("reset_busy",    32'(ba), 0);
    chk("reset_overrun", 32'(ova), 0);
    chk("reset_perr",    32'(pea), 0);
    chk("reset_ferr",    32'(fea), 0);
    rst = 1'b0;
    clks(5);

    // 8N1 word with consumer ready: single-cycle valid.
    n = cnt_a;
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1'b1, 1'b1, 1);
    chk("a5_valid_cycles", 32'(cnt_a - n), 1);
    chk("a5_data",  32'(cap_da), 32'h0A5);
    chk("a5_perr",  32'(cap_pea), 0);
    chk("a5_ferr",  32'(cap_fea), 0);
    chk("a5_valid_low", 32'(va), 0);

    // 7E1: 0x41 has two ones, so parity bit 1 is wrong and 0 is right.
    n = cnt_b;
    send_frame(1, 9'h041, 7, 1, 1'b1, 1'b1, 1'b1, 1);
    chk("p1_count", 32'(cnt_b - n), 1);
    chk("p1_data",  32'(cap_db), 32'h41);
    chk("p1_perr",  32'(cap_peb), 1);
    n = cnt_b;
    send_frame(1, 9'h041, 7, 1, 1'b0, 1'b1, 1'b1, 1);
    chk("p0_count", 32'(cnt_b - n), 1);
    chk("p0_data",  32'(cap_db), 32'h41);
    chk("p0_perr",  32'(cap_peb), 0);

    // Short low glitch (4 ticks) is a false start.
    n = cnt_a;
    set_rx(0, 1'b0); clks(8); set_rx(0, 1'b1);
    chk("glitch_busy_hi", 32'(ba), 1);
    clks(60);
    chk("glitch_busy_lo", 32'(ba), 0);
    chk("glitch_no_word", 32'(cnt_a - n), 0);

    // 8N2 with a bad second stop bit, then a clean frame.
    n = cnt_c;
    send_frame(2, 9'h03C, 8, 0, 1'b0, 1'b1, 1'b0, 2);
    chk("fe_count", 32'(cnt_c - n), 1);
    chk("fe_data",  32'(cap_dc), 32'h3C);
    chk("fe_ferr",  32'(cap_fec), 1);
    chk("fe_perr",  32'(cap_pec), 0);
    n = cnt_c;
    send_frame(2, 9'h05A, 8, 0, 1'b0, 1'b1, 1'b1, 2);
    chk("ok_count", 32'(cnt_c - n), 1);
    chk("ok_data",  32'(cap_dc), 32'h5A);
    chk("ok_ferr",  32'(cap_fec), 0);

    // Overrun: second word dropped while the first is held.
    ready = 1'b0;
    send_frame(0, 9'h011, 8, 0, 1'b0, 1'b1, 1'b1, 1);
    chk("hold_valid",   32'(va), 1);
    chk("hold_data",    32'(da), 32'h11);
    chk("hold_overrun", 32'(ova), 0);
    send_frame(0, 9'h022, 8, 0, 1'b0, 1'b1, 1'b1, 1);
    chk("ovr_valid",   32'(va), 1);
    chk("ovr_data",    32'(da), 32'h11);
    chk("ovr_overrun", 32'(ova), 1);
    ready = 1'b1;
    clks(1);
    chk("ack_valid",   32'(va), 0);
    chk("ack_overrun", 32'(ova), 0);

    // Reset in the middle of data bit 3 of 0xFF.
    n = cnt_a;
    set_rx(0, 1'b0); clks(32);
    set_rx(0, 1'b1); clks(3 * 32 + 16);
    chk("mid_busy", 32'(ba), 1);
    rst = 1'b1;
    #1;
    chk("rst_valid",   32'(va), 0);
    chk("rst_data",    32'(da), 0);
    chk("rst_busy",    32'(ba), 0);
    chk("rst_perr",    32'(pea), 0);
    chk("rst_ferr",    32'(fea), 0);
    chk("rst_overrun", 32'(ova), 0);
    clks(10);
    rst = 1'b0;
    clks(200);
    chk("post_rst_idle",    32'(ba), 0);
    chk("post_rst_no_word", 32'(cnt_a - n), 0);
    n = cnt_a;
    send_frame(0, 9'h081, 8, 0, 1'b0, 1'b1, 1'b1, 1);
    chk("r81_count", 32'(cnt_a - n), 1);
    chk("r81_data",  32'(cap_da), 32'h81);
    chk("r81_ferr",  32'(cap_fea), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
